// File: rtl/fmanorm_pkg.sv
// rtl/fmanorm_pkg.sv - format constants, bias-correction/subnormal-bound tables and stage payload types
package fmanorm_pkg;
    localparam int NE      = 11;
    localparam int NF      = 52;
    localparam int NF1     = 23;
    localparam int BIAS    = 1023;
    localparam int BIAS1   = 127;
    localparam int FMALEN  = 3*NF + 6;
    localparam int FMTBITS = 1;
    localparam int EW      = NE + 2;
    localparam int SHW_W   = $clog2(FMALEN + 1);

    localparam logic [FMTBITS-1:0] FMT_WIDE = FMTBITS'(1);
    localparam logic [FMTBITS-1:0] FMT_1    = FMTBITS'(0);

    typedef logic [EW-1:0] exp_t;

    // lez: upper subnormal bound, gefl: smallest representable subnormal exponent
    typedef struct packed {
        logic valid;
        exp_t lez;
        exp_t gefl;
    } bound_t;

    typedef struct packed {
        exp_t               p;
        exp_t               corr;
        logic [FMTBITS-1:0] fmt;
        logic               zero;
        logic [SHW_W-1:0]   se_lo;
        logic [SHW_W-1:0]   scnt;
    } s1_t;

    typedef struct packed {
        exp_t             norm_exp;
        logic             zero;
        logic             subnorm;
        logic [SHW_W-1:0] shamt;
        logic             uflow;
    } s2_t;

    function automatic exp_t bias_corr(input logic [FMTBITS-1:0] fmt);
        exp_t c;
        c = '0;
        case (fmt)
            FMT_1:   c = EW'(BIAS1 - BIAS);
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic bound_t sub_bounds(input logic [FMTBITS-1:0] fmt);
        bound_t b;
        b = '0;
        case (fmt)
            FMT_WIDE: begin
                b.valid = 1'b1;
                b.lez   = '0;
                b.gefl  = EW'(-(NF + 1));
            end
            FMT_1: begin
                b.valid = 1'b1;
                b.lez   = EW'(BIAS - BIAS1);
                b.gefl  = EW'(BIAS - BIAS1 - NF1 - 1);
            end
            default: b = '0;
        endcase
        return b;
    endfunction
endpackage

// File: rtl/fmanormlane.sv
// rtl/fmanormlane.sv - per-lane combinational arithmetic for both pipeline stages
module fmanormlane
    import fmanorm_pkg::*;
(
    input  logic [FMTBITS-1:0] fmt,
    input  exp_t               se,
    input  logic [FMALEN-1:0]  sm,
    input  logic [SHW_W-1:0]   scnt,
    output s1_t                s1_d,
    input  s1_t                s1_q,
    output s2_t                s2_d
);
    bound_t b;
    logic   p_zero;
    logic   le;
    logic   ge;

    always_comb begin
        s1_d.p     = se - EW'(scnt) + EW'(NF + 3);
        s1_d.corr  = bias_corr(fmt);
        s1_d.fmt   = fmt;
        s1_d.zero  = ~|sm;
        s1_d.se_lo = se[SHW_W-1:0];
        s1_d.scnt  = scnt;
    end

    // shift amount only needs the low bits of Se + NF + 3 + BiasCorr, so se_lo suffices
    always_comb begin
        b      = sub_bounds(s1_q.fmt);
        p_zero = (s1_q.p == '0);
        le     = $signed(s1_q.p) <= $signed(b.lez);
        ge     = $signed(s1_q.p) >= $signed(b.gefl);
        s2_d.norm_exp = s1_q.p + s1_q.corr;
        s2_d.zero     = s1_q.zero;
        s2_d.subnorm  = b.valid & le & (ge | p_zero);
        s2_d.shamt    = s2_d.subnorm ? (s1_q.se_lo + SHW_W'(NF + 3) + s1_q.corr[SHW_W-1:0])
                                     : (s1_q.scnt + SHW_W'(1));
        s2_d.uflow    = b.valid & ~s1_q.zero & ~ge;
    end
endmodule

// File: rtl/fmanormcalc_pipe.sv
// rtl/fmanormcalc_pipe.sv - two-stage multi-lane FMA normalization calculator with valid/ready and flush
module fmanormcalc_pipe
    import fmanorm_pkg::*;
#(
    parameter int LANES = 1,
    parameter int SHW   = $clog2(FMALEN + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     Flush,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [LANES*FMTBITS-1:0] Fmt,
    input  logic [LANES*EW-1:0]      FmaSe,
    input  logic [LANES*FMALEN-1:0]  FmaSm,
    input  logic [LANES*SHW-1:0]     FmaSCnt,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [LANES*EW-1:0]      NormSumExp,
    output logic [LANES-1:0]         FmaSZero,
    output logic [LANES-1:0]         FmaPreResultSubnorm,
    output logic [LANES*SHW-1:0]     FmaShiftAmt,
    output logic [LANES-1:0]         FmaTotalUnderflow
);
    logic v1;
    logic v2;
    logic adv2;
    logic load1;
    logic load2;

    assign adv2     = ~v2 | OutReady;
    // a flushed op is dropped anyway, so accepting it during Flush costs nothing
    assign InReady  = ~v1 | adv2 | Flush;
    assign load1    = InValid & InReady;
    assign load2    = adv2 & v1;
    assign OutValid = v2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (Flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (InReady) v1 <= InValid;
            if (adv2)    v2 <= v1;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        s1_t s1_d;
        s1_t s1_q;
        s2_t s2_d;
        s2_t s2_q;

        fmanormlane u_lane (
            .fmt  (Fmt[l*FMTBITS +: FMTBITS]),
            .se   (FmaSe[l*EW +: EW]),
            .sm   (FmaSm[l*FMALEN +: FMALEN]),
            .scnt (FmaSCnt[l*SHW +: SHW]),
            .s1_d (s1_d),
            .s1_q (s1_q),
            .s2_d (s2_d)
        );

        always_ff @(posedge clk) begin
            if (load1) s1_q <= s1_d;
            if (load2) s2_q <= s2_d;
        end

        assign NormSumExp[l*EW +: EW]    = s2_q.norm_exp;
        assign FmaSZero[l]               = s2_q.zero;
        assign FmaPreResultSubnorm[l]    = s2_q.subnorm;
        assign FmaShiftAmt[l*SHW +: SHW] = s2_q.shamt;
        assign FmaTotalUnderflow[l]      = s2_q.uflow;
    end
endmodule
